mem_wb_stage: RTL and testbench

Memory-access stage of the pipelined MIPS core. It takes an instruction from the EX/MEM register and, for loads and stores, runs a request/ready transaction with the data memory. It produces the registered writeback bundle: data, destination register and write enable. While a memory transaction is outstanding it asserts `stall`, which freezes the upstream stages and the PC writeback pipeline register that travels alongside this bundle.

---
 rtl/mem_wb_pkg.sv | 24 ++
 rtl/mem_wb_if.sv | 20 ++
 rtl/load_align.sv | 22 ++
 rtl/mem_wb_stage.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pkg.sv
// Shared encodings and helpers for the MEM/WB stage: access sizes, FSM states,
// byte-lane enable and alignment decode.
package mem_wb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Size 2'b11 decodes as a word, so any size with bit 1 set needs full alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_wb_if.sv
// Data-memory request/ready bus between the MEM/WB stage (master) and memory (slave).
interface mem_wb_if #(parameter int ADDR_W = 32) ();
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ready;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Load data extraction: shift the addressed lane down and sign/zero extend.
module load_align
  import mem_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] data
);
  logic [31:0] w_shift;

  assign w_shift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    case (size)
      SZ_BYTE: data = {{24{~unsigned_ld & w_shift[7]}},  w_shift[7:0]};
      SZ_HALF: data = {{16{~unsigned_ld & w_shift[15]}}, w_shift[15:0]};
      default: data = w_shift;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage: issues one data-memory transaction per load/store,
// stalls upstream until ready, and registers the writeback bundle.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  mem_wb_if.master    dmem,
  output logic        stall,
  output logic        misalign,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data
);
  state_e            r_state, w_next;
  logic              r_we, r_reg_write, r_mem_to_reg, r_unsigned, r_misalign;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_alu, r_wb_data;
  logic [4:0]        r_rd, r_wb_rd;
  logic [1:0]        r_size, r_addr_lo;
  logic              r_wb_valid, r_wb_reg_write;
  logic              w_mem_op, w_misal, w_issue;
  logic [31:0]       w_wdata, w_load;

  assign w_mem_op = in_valid & (in_mem_read | in_mem_write);
  assign w_misal  = misaligned(in_size, in_alu_result[1:0]);
  assign w_issue  = w_mem_op & ~w_misal;

  always_comb begin
    case (in_size)
      SZ_BYTE: w_wdata = {4{in_store_data[7:0]}};
      SZ_HALF: w_wdata = {2{in_store_data[15:0]}};
      default: w_wdata = in_store_data;
    endcase
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_issue;
        if (w_issue) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        stall = ~dmem.dmem_ready;
        if (dmem.dmem_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata       (dmem.dmem_rdata),
    .addr_lo     (r_addr_lo),
    .size        (r_size),
    .unsigned_ld (r_unsigned),
    .data        (w_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_alu          <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_unsigned     <= 1'b0;
      r_size         <= '0;
      r_addr_lo      <= '0;
      r_misalign     <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_data      <= '0;
    end else begin
      r_state    <= w_next;
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_we           <= in_mem_write;
            r_addr         <= ADDR_W'({in_alu_result[31:2], 2'b00});
            r_be           <= byte_enable(in_size, in_alu_result[1:0]);
            r_wdata        <= w_wdata;
            r_alu          <= in_alu_result;
            r_rd           <= in_rd;
            // A combined read+write performs the store and must not write the RF.
            r_reg_write    <= in_reg_write & ~(in_mem_read & in_mem_write);
            r_mem_to_reg   <= in_mem_to_reg;
            r_unsigned     <= in_unsigned;
            r_size         <= in_size;
            r_addr_lo      <= in_alu_result[1:0];
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
          end else if (w_mem_op) begin
            r_misalign     <= 1'b1;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
          end else begin
            r_wb_valid     <= in_valid;
            r_wb_rd        <= in_rd;
            r_wb_reg_write <= in_reg_write;
            r_wb_data      <= in_alu_result;
          end
        end
        ST_ACCESS: begin
          if (dmem.dmem_ready) begin
            r_wb_valid     <= 1'b1;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= r_reg_write;
            r_wb_data      <= r_mem_to_reg ? w_load : r_alu;
          end else begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req   = (r_state == ST_ACCESS);
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;
  assign misalign        = r_misalign;
  assign wb_valid        = r_wb_valid;
  assign wb_rd           = r_wb_rd;
  assign wb_reg_write    = r_wb_reg_write;
  assign wb_data         = r_wb_data;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage with an arithmetic reference model.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_unsigned, in_reg_write, in_mem_to_reg;
  logic [1:0]  in_size;
  logic [31:0] in_alu_result, in_store_data;
  logic [4:0]  in_rd;
  logic        stall, misalign, wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          checks = 0;
  int          errors = 0;

  mem_wb_if #(.ADDR_W(32)) bus ();

  mem_wb_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .dmem(bus.master), .stall(stall), .misalign(misalign),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int lo, input int sz, input bit uns);
    logic [31:0] v;
    v = rd >> (8 * lo);
    if (sz == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req"}, 32'(bus.dmem_req), 0);
    chk({tag, ".we"}, 32'(bus.dmem_we), 0);
    chk({tag, ".addr"}, bus.dmem_addr, 0);
    chk({tag, ".be"}, 32'(bus.dmem_be), 0);
    chk({tag, ".wdata"}, bus.dmem_wdata, 0);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 0);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 0);
    chk({tag, ".wb_rw"}, 32'(wb_reg_write), 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".misalign"}, 32'(misalign), 0);
  endtask

  // Presents one instruction and runs it to completion; w = ACCESS cycles up to ready.
  task automatic run_op(input string tag, input bit v, input bit rd_, input bit wr_,
                        input int sz, input bit uns, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd, input bit regw,
                        input bit m2r, input int w, input logic [31:0] rdv);
    bit mem, mis;
    int lo;
    logic [31:0] e_be, e_wd;
    in_valid = v; in_mem_read = rd_; in_mem_write = wr_; in_size = 2'(sz);
    in_unsigned = uns; in_alu_result = alu; in_store_data = sd; in_rd = rd;
    in_reg_write = regw; in_mem_to_reg = m2r;
    bus.dmem_ready = 1'($urandom % 2);
    bus.dmem_rdata = $urandom;
    #1;
    mem = v && (rd_ || wr_);
    lo  = alu % 4;
    mis = (sz == 1 && (lo % 2) == 1) || (sz >= 2 && lo != 0);
    chk({tag, ".stall_idle"}, 32'(stall), 32'(mem && !mis));
    chk({tag, ".req_idle"}, 32'(bus.dmem_req), 0);
    step();
    if (!mem) begin
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ".wb_rw"}, 32'(wb_reg_write), 32'(regw));
      chk({tag, ".wb_data"}, wb_data, alu);
      chk({tag, ".misalign"}, 32'(misalign), 0);
    end else if (mis) begin
      chk({tag, ".misalign"}, 32'(misalign), 1);
      chk({tag, ".wb_valid"}, 32'(wb_valid), 0);
      chk({tag, ".req"}, 32'(bus.dmem_req), 0);
      in_valid = 1'b0;
      step();
      chk({tag, ".misalign_drop"}, 32'(misalign), 0);
    end else begin
      e_be = (sz == 0) ? (32'd1 << lo) : (sz == 1) ? (32'd3 << lo) : 32'd15;
      e_wd = (sz == 0) ? (sd % 256) * 32'h0101_0101 :
             (sz == 1) ? (sd % 65536) * 32'h0001_0001 : sd;
      for (int k = 1; k <= w; k++) begin
        bus.dmem_ready = (k == w);
        bus.dmem_rdata = (k == w) ? rdv : $urandom;
        #1;
        chk({tag, ".req"}, 32'(bus.dmem_req), 1);
        chk({tag, ".we"}, 32'(bus.dmem_we), 32'(wr_));
        chk({tag, ".addr"}, bus.dmem_addr, alu - 32'(lo));
        chk({tag, ".be"}, 32'(bus.dmem_be), e_be);
        chk({tag, ".wdata"}, bus.dmem_wdata, e_wd);
        chk({tag, ".stall_acc"}, 32'(stall), 32'(k != w));
        chk({tag, ".bubble"}, 32'(wb_valid), 0);
        step();
      end
      bus.dmem_ready = 1'b0;
      chk({tag, ".wb_valid"}, 32'(wb_valid), 1);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ".wb_rw"}, 32'(wb_reg_write), 32'(regw && !(rd_ && wr_)));
      chk({tag, ".wb_data"}, wb_data, m2r ? exp_load(rdv, lo, sz, uns) : alu);
      chk({tag, ".req_done"}, 32'(bus.dmem_req), 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_size = 0; in_unsigned = 0;
    in_alu_result = 0; in_store_data = 0; in_rd = 0; in_reg_write = 0; in_mem_to_reg = 0;
    bus.dmem_ready = 0; bus.dmem_rdata = 0;
    #12;
    check_reset_outputs("reset");
    chk("reset.stall", 32'(stall), 0);
    step();
    reset = 1'b1;
    step();

    run_op("alu",  1, 0, 0, 2, 0, 32'h0000_1234, 0, 5, 1, 0, 1, 0);
    run_op("lw",   1, 1, 0, 2, 0, 32'h0000_0100, 0, 7, 1, 1, 3, 32'hDEAD_BEEF);
    run_op("lb",   1, 1, 0, 0, 0, 32'h0000_0103, 0, 8, 1, 1, 1, 32'h8012_3456);
    run_op("lbu",  1, 1, 0, 0, 1, 32'h0000_0103, 0, 9, 1, 1, 1, 32'h8012_3456);
    run_op("lh",   1, 1, 0, 1, 0, 32'h0000_0202, 0, 10, 1, 1, 2, 32'h9ABC_0000);
    run_op("sh",   1, 0, 1, 1, 0, 32'h0000_0102, 32'h0000_ABCD, 3, 0, 0, 1, 0);
    run_op("sb",   1, 0, 1, 0, 0, 32'h0000_0201, 32'h1234_5677, 3, 0, 0, 2, 0);
    run_op("rdwr", 1, 1, 1, 2, 0, 32'h0000_0300, 32'hCAFE_F00D, 4, 1, 0, 1, 32'h1111_2222);
    run_op("lwmis",1, 1, 0, 2, 0, 32'h0000_0101, 0, 6, 1, 1, 1, 0);
    run_op("lhmis",1, 1, 0, 1, 0, 32'h0000_0103, 0, 6, 1, 1, 1, 0);
    run_op("bubble",0, 1, 0, 2, 0, 32'h0000_0044, 0, 2, 1, 0, 1, 0);

    for (int i = 0; i < 200; i++) begin
      run_op("rnd", ($urandom % 8) != 0, 1'($urandom), 1'($urandom), int'($urandom % 4),
             1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(1, 4)), $urandom);
    end

    // Reset in the middle of an access; the late ready must not produce a writeback.
    in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_size = 2'b10;
    in_alu_result = 32'h0000_0400; in_rd = 12; in_reg_write = 1; in_mem_to_reg = 1;
    bus.dmem_ready = 0;
    step();
    chk("rst_mid.req_before", 32'(bus.dmem_req), 1);
    in_valid = 0;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    bus.dmem_ready = 1; bus.dmem_rdata = 32'h5555_AAAA;
    step();
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    step();
    bus.dmem_ready = 0;
    chk("rst_rel.wb_valid", 32'(wb_valid), 0);
    chk("rst_rel.req", 32'(bus.dmem_req), 0);
    step();
    chk("rst_rel2.wb_valid", 32'(wb_valid), 0);
    chk("rst_rel2.req", 32'(bus.dmem_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
